// File: rtl/rx_class_pkg.sv
// Shared type codes, class indices and FSM state for the receive class demux.
// Class index k equals type code k for the five legal codes; codes 5-7 are illegal.
package rx_class_pkg;

   localparam logic [2:0] TYPE_AW      = 3'd0;
   localparam logic [2:0] TYPE_AR      = 3'd1;
   localparam logic [2:0] TYPE_R       = 3'd2;
   localparam logic [2:0] TYPE_B       = 3'd3;
   localparam logic [2:0] TYPE_BARRIER = 3'd4;

   localparam int CLS_AW      = 0;
   localparam int CLS_AR      = 1;
   localparam int CLS_R       = 2;
   localparam int CLS_B       = 3;
   localparam int CLS_BARRIER = 4;
   localparam int NUM_CLS     = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   // Illegal codes decode to all-zero, so legality is just |onehot.
   function automatic logic [NUM_CLS-1:0] type_onehot(input logic [2:0] t);
      logic [NUM_CLS-1:0] oh;
      oh = '0;
      case (t)
         TYPE_AW:      oh[CLS_AW]      = 1'b1;
         TYPE_AR:      oh[CLS_AR]      = 1'b1;
         TYPE_R:       oh[CLS_R]       = 1'b1;
         TYPE_B:       oh[CLS_B]       = 1'b1;
         TYPE_BARRIER: oh[CLS_BARRIER] = 1'b1;
         default:      oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rx_out_reg.sv
// One-entry valid/ready output register; latency 1, refills in the same cycle it drains.
// Holds its contents stable while the selected class_ready is low.
module rx_out_reg
   import rx_class_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int CONN_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [NUM_CLS-1:0] in_cls,
   input  logic [CONN_W-1:0]  in_conn,
   input  logic               in_last,
   input  logic [DATA_W-1:0]  in_data,
   output logic               slot_free,
   output logic [NUM_CLS-1:0] class_valid,
   input  logic [NUM_CLS-1:0] class_ready,
   output logic [DATA_W-1:0]  dout,
   output logic               dout_last,
   output logic [CONN_W-1:0]  dout_conn
);

   typedef struct packed {
      logic [NUM_CLS-1:0] cls;
      logic [CONN_W-1:0]  conn;
      logic               last;
      logic [DATA_W-1:0]  data;
   } entry_t;

   entry_t q;

   assign slot_free   = ~(|q.cls) | (|(q.cls & class_ready));
   assign class_valid = q.cls;
   assign dout        = q.data;
   assign dout_last   = q.last;
   assign dout_conn   = q.conn;

   // load is only asserted when slot_free, so overwriting never loses a beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q.cls  <= in_cls;
         q.conn <= in_conn;
         q.last <= in_last;
         q.data <= in_data;
      end else if (slot_free) begin
         q.cls <= '0;
      end
   end

endmodule

// File: rtl/rx_class_demux.sv
// Steers whole packets to AW/AR/R/B/BARRIER by header type; latency 1, drops illegal/disabled packets.
// rx_ready follows the output slot except for drops, which always sink; RX_STATS_EN adds counters.
module rx_class_demux
   import rx_class_pkg::*;
#(
   parameter int DATA_W   = 128,
   parameter int CONN_W   = 4,
   parameter int TYPE_LSB = DATA_W - 3,
   parameter int STAT_W   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [(2**CONN_W)-1:0]   conn_en,
   input  logic [DATA_W-1:0]        rx_data,
   input  logic [CONN_W-1:0]        rx_connection_id,
   input  logic                     rx_last,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [DATA_W-1:0]        dout,
   output logic                     dout_last,
   output logic [CONN_W-1:0]        dout_conn,
   output logic [NUM_CLS-1:0]       class_valid,
   input  logic [NUM_CLS-1:0]       class_ready,
   output logic [NUM_CLS*STAT_W-1:0] pkt_cnt,
   output logic [STAT_W-1:0]        drop_cnt
);

   state_t             state;
   logic [NUM_CLS-1:0] cls_q;
   logic [CONN_W-1:0]  conn_q;

   logic [NUM_CLS-1:0] hdr_cls;
   logic               hdr_ok;
   logic               slot_free;
   logic               accept;
   logic               hdr_acc;
   logic               load;

   assign hdr_cls = type_onehot(rx_data[TYPE_LSB +: 3]);
   assign hdr_ok  = (|hdr_cls) & conn_en[rx_connection_id];

   // A rejected header never touches the output register, so it need not wait for it.
   always_comb begin
      rx_ready = 1'b0;
      if (!reset) begin
         case (state)
            IDLE:    rx_ready = slot_free | ~hdr_ok;
            FWD:     rx_ready = slot_free;
            DROP:    rx_ready = 1'b1;
            default: rx_ready = 1'b0;
         endcase
      end
   end

   assign accept  = rx_valid & rx_ready;
   assign hdr_acc = accept & (state == IDLE);
   assign load    = (hdr_acc & hdr_ok) | (accept & (state == FWD));

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cls_q  <= '0;
         conn_q <= '0;
      end else if (accept) begin
         case (state)
            IDLE: begin
               cls_q  <= hdr_cls;
               conn_q <= rx_connection_id;
               if (!rx_last)
                  state <= hdr_ok ? FWD : DROP;
            end
            FWD, DROP: begin
               if (rx_last)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   rx_out_reg #(
      .DATA_W (DATA_W),
      .CONN_W (CONN_W)
   ) u_out (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .in_cls      ((state == IDLE) ? hdr_cls : cls_q),
      .in_conn     ((state == IDLE) ? rx_connection_id : conn_q),
      .in_last     (rx_last),
      .in_data     (rx_data),
      .slot_free   (slot_free),
      .class_valid (class_valid),
      .class_ready (class_ready),
      .dout        (dout),
      .dout_last   (dout_last),
      .dout_conn   (dout_conn)
   );

`ifdef RX_STATS_EN
   localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

   logic [STAT_W-1:0] pkt_q [NUM_CLS];
   logic [STAT_W-1:0] drop_q;

   // Counted at the header so a packet is counted once; saturate at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CLS; k++)
            pkt_q[k] <= '0;
         drop_q <= '0;
      end else if (hdr_acc) begin
         for (int k = 0; k < NUM_CLS; k++)
            if (hdr_ok && hdr_cls[k] && (pkt_q[k] != '1))
               pkt_q[k] <= pkt_q[k] + STAT_ONE;
         if (!hdr_ok && (drop_q != '1))
            drop_q <= drop_q + STAT_ONE;
      end
   end

   always_comb begin
      pkt_cnt = '0;
      for (int k = 0; k < NUM_CLS; k++)
         pkt_cnt[k*STAT_W +: STAT_W] = pkt_q[k];
   end
   assign drop_cnt = drop_q;
`else
   assign pkt_cnt  = '0;
   assign drop_cnt = '0;
`endif

endmodule
